// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus_rw_arbiter block.
// State encoding, R_nW polarity and bus output-enable patterns.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic R_NW_READ  = 1'b1;
    localparam logic R_NW_WRITE = 1'b0;

    // Sized for the widest supported bus; users slice [DW-1:0].
    localparam int              MAX_DW     = 64;
    localparam logic [MAX_DW-1:0] OE_DRIVE   = {MAX_DW{1'b1}};
    localparam logic [MAX_DW-1:0] OE_RELEASE = {MAX_DW{1'b0}};

endpackage

// File: rtl/bus_rw_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    // Walk offsets from farthest to nearest so the closest requester overwrites.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/bus_rw_arbiter.sv
// Round-robin sequencer sharing a tri-state R/W* register among NREQ requesters.
// Optional per-requester grant counters enabled by macro BUS_ARB_STATS_EN.
module bus_rw_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 r_nw,
    output logic [DW-1:0]        bus_out,
    output logic [DW-1:0]        bus_oe,
    input  logic [DW-1:0]        bus_in,
    output logic [NREQ*DW-1:0]   stat_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx_q;
    logic          we_q;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // bus_out doubles as the latched write data, so it is only loaded at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            gnt     <= '0;
            done    <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
            r_nw    <= R_NW_READ;
            bus_out <= '0;
            bus_oe  <= OE_RELEASE[DW-1:0];
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state <= S_XFER;
                        idx_q <= pick_idx;
                        we_q  <= we[pick_idx];
                        gnt   <= NREQ'(1) << pick_idx;
                        busy  <= 1'b1;
                        if (we[pick_idx]) begin
                            r_nw    <= R_NW_WRITE;
                            bus_oe  <= OE_DRIVE[DW-1:0];
                            bus_out <= wdata[pick_idx*DW +: DW];
                        end else begin
                            r_nw   <= R_NW_READ;
                            bus_oe <= OE_RELEASE[DW-1:0];
                        end
                    end
                end
                S_XFER: begin
                    state  <= S_DONE;
                    r_nw   <= R_NW_READ;
                    bus_oe <= OE_RELEASE[DW-1:0];
                    done   <= 1'b1;
                    if (!we_q) begin
                        rdata <= bus_in;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BUS_ARB_STATS_EN
    logic [DW-1:0] cnt [NREQ];

    // Counters bump as each transaction retires and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == S_DONE && cnt[idx_q] != {DW{1'b1}}) begin
            cnt[idx_q] <= cnt[idx_q] + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_cnt[g*DW +: DW] = cnt[g];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
